sd_disk_arbiter: RTL and testbench

- Schedules block requests from up to four virtual-disk clients onto the hps_io per-drive request lines: FDD0, FDD1, SASI and SRAM.
- Guarantees exactly one transaction in flight on the shared sd_lba / sd_buff_* bus.
- Forwards ack and buffer strobes to the granted client only.
- Sits in emu between the X68000 core's disk controllers and hps_io (VDNUM=4), all in the clk_sys domain.

---
 rtl/sd_disk_arbiter_pkg.sv | 24 ++
 rtl/sd_disk_arbiter_if.sv | 34 +++
 rtl/sd_disk_arbiter_rr_pick.sv | 32 +++
 rtl/sd_disk_arbiter.sv | 140 ++++++++++++++
 tb/tb_sd_disk_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_disk_arbiter_pkg.sv
// Shared types and helpers for the SD disk arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sd_arb_pkg;

  localparam int NUM_DEV_DEF = 4;
  localparam int LBA_W_DEF   = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    XFER,
    DONE,
    REL
  } state_t;

  // One-hot decode of a slot index; callers truncate to their slot count.
  function automatic logic [31:0] onehot(input int idx);
    logic [31:0] r;
    r = 32'd1 << idx;
    return r;
  endfunction

endpackage

// File: rtl/sd_disk_arbiter_if.sv
// Client-side and hps_io-side signal bundle of the SD disk arbiter.
// Latency: n/a (wires only).
// Backpressure: n/a; clients hold level requests until their done pulse.
// slave  : arbiter view (client requests and hps_io ack/strobe in; grants and hps_io requests out).
// master : environment view (clients plus hps_io), the mirror of slave.
interface sd_disk_arbiter_if #(
  parameter int NUM_DEV = 4,
  parameter int LBA_W   = 32
);
  logic [NUM_DEV-1:0]       cl_rd;
  logic [NUM_DEV-1:0]       cl_wr;
  logic [NUM_DEV*LBA_W-1:0] cl_lba;
  logic [NUM_DEV*8-1:0]     cl_buff_din;
  logic [NUM_DEV-1:0]       cl_ack;
  logic [NUM_DEV-1:0]       cl_buff_wr;
  logic [NUM_DEV-1:0]       cl_done;
  logic [NUM_DEV-1:0]       cl_err;
  logic [LBA_W-1:0]         sd_lba;
  logic [NUM_DEV-1:0]       sd_rd;
  logic [NUM_DEV-1:0]       sd_wr;
  logic [NUM_DEV-1:0]       sd_ack;
  logic                     sd_buff_wr;
  logic [7:0]               sd_buff_din;

  modport slave (
    input  cl_rd, cl_wr, cl_lba, cl_buff_din, sd_ack, sd_buff_wr,
    output cl_ack, cl_buff_wr, cl_done, cl_err, sd_lba, sd_rd, sd_wr, sd_buff_din
  );

  modport master (
    output cl_rd, cl_wr, cl_lba, cl_buff_din, sd_ack, sd_buff_wr,
    input  cl_ack, cl_buff_wr, cl_done, cl_err, sd_lba, sd_rd, sd_wr, sd_buff_din
  );
endinterface

// File: rtl/sd_disk_arbiter_rr_pick.sv
// Round-robin priority picker: first requesting slot after last_g_i, wrapping.
// Latency: combinational.
// Backpressure: none; any_o low when no slot requests.
// Ports: req_i (per-slot request), last_g_i (previous grant), any_o, g_o (chosen slot).
module rr_pick #(
  parameter int NUM_DEV = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_DEV-1:0] req_i,
  input  logic [GW-1:0]      last_g_i,
  output logic               any_o,
  output logic [GW-1:0]      g_o
);

  logic [GW-1:0] cand;

  // Scan from the far end back towards last_g+1 so the nearest candidate
  // is written last and wins.
  always_comb begin
    any_o = 1'b0;
    g_o   = '0;
    cand  = '0;
    for (int k = NUM_DEV; k >= 1; k--) begin
      cand = GW'((int'(last_g_i) + k) % NUM_DEV);
      if (req_i[cand]) begin
        any_o = 1'b1;
        g_o   = cand;
      end
    end
  end

endmodule

// File: rtl/sd_disk_arbiter.sv
// Serialises virtual-disk client block requests onto the hps_io per-drive lines.
// Latency: request to sd_rd/sd_wr 2 cycles; 2 idle cycles minimum between transactions.
// Backpressure: one transaction in flight; other clients hold requests until granted.
// Ports: clk_sys, reset (async, active high), bus (sd_disk_arbiter_if.slave).
// Optional: define SD_ARB_TIMEOUT_EN to enable the TIMEOUT_CYC watchdog and cl_err.
module sd_disk_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NUM_DEV = NUM_DEV_DEF,
  parameter int LBA_W   = LBA_W_DEF
`ifdef SD_ARB_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_CYC = 24'd8_000_000
`endif
) (
  input logic              clk_sys,
  input logic              reset,
  sd_disk_arbiter_if.slave bus
);

  localparam int GW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  state_t               state_q;
  logic [GW-1:0]        g_q;
  logic [GW-1:0]        last_g_q;
  logic                 dir_q;
  logic [LBA_W-1:0]     sd_lba_q;
  logic [NUM_DEV-1:0]   sd_rd_q;
  logic [NUM_DEV-1:0]   sd_wr_q;
  logic [NUM_DEV-1:0]   cl_done_q;
  logic [NUM_DEV-1:0]   req;
  logic [NUM_DEV-1:0]   gsel;
  logic [GW-1:0]        pick;
  logic                 any_req;
  logic                 to_hit;

  assign req  = bus.cl_rd | bus.cl_wr;
  assign gsel = NUM_DEV'(onehot(int'(g_q)));

  rr_pick #(.NUM_DEV(NUM_DEV), .GW(GW)) u_pick (
    .req_i    (req),
    .last_g_i (last_g_q),
    .any_o    (any_req),
    .g_o      (pick)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      last_g_q  <= GW'(NUM_DEV - 1);
      dir_q     <= 1'b0;
      sd_lba_q  <= '0;
      sd_rd_q   <= '0;
      sd_wr_q   <= '0;
      cl_done_q <= '0;
    end else begin
      cl_done_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            g_q      <= pick;
            last_g_q <= pick;
            dir_q    <= bus.cl_wr[pick];
            sd_lba_q <= bus.cl_lba[int'(pick)*LBA_W +: LBA_W];
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (to_hit) begin
            sd_rd_q   <= '0;
            sd_wr_q   <= '0;
            cl_done_q <= gsel;
            state_q   <= REL;
          end else if (bus.sd_ack[g_q]) begin
            sd_rd_q <= '0;
            sd_wr_q <= '0;
            state_q <= XFER;
          end else begin
            sd_rd_q <= dir_q ? '0 : gsel;
            sd_wr_q <= dir_q ? gsel : '0;
          end
        end
        XFER: begin
          if (to_hit) begin
            cl_done_q <= gsel;
            state_q   <= REL;
          end else if (!bus.sd_ack[g_q]) begin
            cl_done_q <= gsel;
            state_q   <= DONE;
          end
        end
        DONE: state_q <= REL;
        // Wait for the client to withdraw so a stale level request is not re-issued.
        REL: begin
          if (!bus.cl_rd[g_q] && !bus.cl_wr[g_q]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0]        cnt_q;
  logic [NUM_DEV-1:0] cl_err_q;

  assign to_hit = (cnt_q == TIMEOUT_CYC - 24'd1);

  // Cleared while idle, so it starts from zero on entry to ISSUE.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      cl_err_q <= '0;
    end else begin
      cl_err_q <= '0;
      case (state_q)
        IDLE:        cnt_q <= '0;
        ISSUE, XFER: begin
          if (to_hit) cl_err_q <= gsel;
          else        cnt_q    <= cnt_q + 24'd1;
        end
        default:     cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.cl_err = cl_err_q;
`else
  assign to_hit     = 1'b0;
  assign bus.cl_err = '0;
`endif

  assign bus.sd_lba      = sd_lba_q;
  assign bus.sd_rd       = sd_rd_q;
  assign bus.sd_wr       = sd_wr_q;
  assign bus.cl_done     = cl_done_q;
  assign bus.cl_ack      = (state_q == ISSUE || state_q == XFER) ? (bus.sd_ack & gsel) : '0;
  assign bus.cl_buff_wr  = (state_q == XFER && bus.sd_buff_wr) ? gsel : '0;
  assign bus.sd_buff_din = bus.cl_buff_din[int'(g_q)*8 +: 8];

endmodule

// File: tb/tb_sd_disk_arbiter.sv
// Self-checking bench for sd_disk_arbiter with an inline hps_io responder.
// Latency: n/a.
// Backpressure: n/a.
module tb_sd_disk_arbiter;

  localparam int ND = 4;
  localparam int LW = 32;
`ifdef SD_ARB_TIMEOUT_EN
  localparam int MAX_STR = 40;
`else
  localparam int MAX_STR = 1024;
`endif

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  sd_disk_arbiter_if #(.NUM_DEV(ND), .LBA_W(LW)) bus ();

  sd_disk_arbiter #(
    .NUM_DEV(ND),
    .LBA_W(LW)
`ifdef SD_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(24'd100)
`endif
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [31:0] lba;
    logic [7:0]  din;
    int          g;
    logic        dir;
    int          ack_dly;
    int          nstr;
    bit          drop;
  } vec_t;

  typedef struct {
    int          g;
    logic        dir;
    logic [31:0] lba;
  } exp_t;

  vec_t vt[12];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive_req(input vec_t v);
    exp_t e;
    for (int i = 0; i < ND; i++) begin
      bus.cl_lba[i*LW +: LW]   = (i == v.g) ? v.lba : (~v.lba - 32'(i));
      bus.cl_buff_din[i*8 +: 8] = (i == v.g) ? v.din : ~v.din;
    end
    bus.cl_rd = v.rd;
    bus.cl_wr = v.wr;
    e.g = v.g; e.dir = v.dir; e.lba = v.lba;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the arbiter to raise a drive request; returns cycles taken.
  task automatic wait_issue(output int lat);
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if ((bus.sd_rd | bus.sd_wr) != 4'b0) break;
    end
  endtask

  task automatic run_txn(input vec_t v);
    int lat, cnt, bad, hold_bad, other, nstr, act_g;
    exp_t e;
    logic [3:0] oh;
    oh    = 4'(1 << v.g);
    other = (v.g + 1) % ND;
    nstr  = (v.nstr > MAX_STR) ? MAX_STR : v.nstr;
    drive_req(v);
    wait_issue(lat);
    check("req_to_issue_latency", 64'(lat), 64'd2);
    e = sb[0];
    check("sd_rd", 64'(bus.sd_rd), e.dir ? 64'd0 : 64'(oh));
    check("sd_wr", 64'(bus.sd_wr), e.dir ? 64'(oh) : 64'd0);
    check("sd_lba", 64'(bus.sd_lba), 64'(e.lba));
    check("sd_buff_din", 64'(bus.sd_buff_din), 64'(v.din));
    if (v.drop) begin
      bus.cl_rd[v.g] = 1'b0;
      bus.cl_wr[v.g] = 1'b0;
    end
    // Stray ack from a non-granted drive must not be forwarded nor advance the FSM.
    bus.sd_ack = 4'(1 << other);
    #2 check("stray_ack_masked", 64'(bus.cl_ack), 64'd0);
    hold_bad = 0;
    for (int k = 0; k < v.ack_dly; k++) begin
      tick();
      bus.sd_ack = 4'b0;
      if ((bus.sd_rd | bus.sd_wr) != oh) hold_bad++;
    end
    check("issue_hold", 64'(hold_bad), 64'd0);
    bus.sd_ack = oh;
    #1 check("cl_ack_grant", 64'(bus.cl_ack), 64'(oh));
    tick();
    check("rdwr_clear_on_ack", 64'(bus.sd_rd | bus.sd_wr), 64'd0);
    cnt = 0;
    bad = 0;
    bus.sd_buff_wr = 1'b1;
    for (int n = 0; n < nstr; n++) begin
      #2;
      if (bus.cl_buff_wr == oh) cnt++;
      else bad++;
      if (bus.sd_buff_din != v.din || bus.sd_lba != e.lba) bad++;
      tick();
    end
    bus.sd_buff_wr = 1'b0;
    check("strobe_count", 64'(cnt), 64'(nstr));
    check("strobe_gating", 64'(bad), 64'd0);
    bus.sd_ack = 4'b0;
    cnt = 0;
    while (cnt < 20) begin
      tick();
      cnt++;
      if (bus.cl_done != 4'b0) break;
    end
    check("cl_done", 64'(bus.cl_done), 64'(oh));
    check("cl_err_clear", 64'(bus.cl_err), 64'd0);
    act_g = -1;
    for (int i = 0; i < ND; i++) if (bus.cl_done[i]) act_g = i;
    if (sb.size() > 0) e = sb.pop_front();
    check("grant_slot", 64'(act_g), 64'(e.g));
    tick();
    check("done_one_cycle", 64'(bus.cl_done), 64'd0);
    hold_bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if ((bus.sd_rd | bus.sd_wr) != 4'b0) hold_bad++;
    end
    check("rel_no_reissue", 64'(hold_bad), 64'd0);
    bus.cl_rd[v.g] = 1'b0;
    bus.cl_wr[v.g] = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, hi;
    vec_t v;
    vt[0]  = '{4'b1011, 4'b0000, 32'h0000_1000, 8'h10, 0, 1'b0, 2, 4, 1'b0};
    vt[1]  = '{4'b1011, 4'b0000, 32'h0000_2001, 8'h21, 1, 1'b0, 1, 4, 1'b0};
    vt[2]  = '{4'b1011, 4'b0000, 32'h0000_3003, 8'h33, 3, 1'b0, 3, 4, 1'b0};
    vt[3]  = '{4'b1011, 4'b0000, 32'h0000_4000, 8'h40, 0, 1'b0, 1, 2, 1'b0};
    vt[4]  = '{4'b1011, 4'b0000, 32'h0000_5001, 8'h51, 1, 1'b0, 2, 2, 1'b0};
    vt[5]  = '{4'b1011, 4'b0000, 32'h0000_6003, 8'h63, 3, 1'b0, 1, 2, 1'b0};
    vt[6]  = '{4'b0100, 4'b0000, 32'h0000_1234, 8'h5C, 2, 1'b0, 5, 512, 1'b0};
    vt[7]  = '{4'b0010, 4'b0010, 32'h0BAD_F00D, 8'hA5, 1, 1'b1, 3, 8, 1'b0};
    vt[8]  = '{4'b0000, 4'b0001, 32'hCAFE_0000, 8'h3C, 0, 1'b1, 1, 3, 1'b0};
    vt[9]  = '{4'b1000, 4'b0100, 32'h7777_0002, 8'h96, 2, 1'b1, 2, 3, 1'b0};
    vt[10] = '{4'b1000, 4'b0000, 32'h8888_0003, 8'h69, 3, 1'b0, 1, 3, 1'b0};
    vt[11] = '{4'b0001, 4'b0000, 32'hFFFF_FFF0, 8'hF0, 0, 1'b0, 2, 2, 1'b1};

    bus.cl_rd = '0; bus.cl_wr = '0; bus.cl_lba = '0; bus.cl_buff_din = '0;
    bus.sd_ack = '0; bus.sd_buff_wr = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_sd_rd", 64'(bus.sd_rd), 64'd0);
    check("rst_sd_wr", 64'(bus.sd_wr), 64'd0);
    check("rst_cl_done", 64'(bus.cl_done), 64'd0);
    check("rst_cl_err", 64'(bus.cl_err), 64'd0);
    check("rst_sd_lba", 64'(bus.sd_lba), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_txn(vt[i]);

    // Asynchronous reset in the middle of a transfer on slot 1.
    v = '{4'b0010, 4'b0000, 32'hDEAD_0001, 8'h11, 1, 1'b0, 0, 0, 1'b0};
    drive_req(v);
    wait_issue(lat);
    check("pre_reset_issue", 64'(bus.sd_rd), 64'h2);
    bus.sd_ack = 4'b0010;
    tick();
    bus.sd_buff_wr = 1'b1;
    #1 check("pre_reset_strobe", 64'(bus.cl_buff_wr), 64'h2);
    reset = 1'b1;
    #1;
    check("arst_sd_rdwr", 64'(bus.sd_rd | bus.sd_wr), 64'd0);
    check("arst_cl_done", 64'(bus.cl_done), 64'd0);
    check("arst_cl_buff_wr", 64'(bus.cl_buff_wr), 64'd0);
    check("arst_cl_ack", 64'(bus.cl_ack), 64'd0);
    check("arst_sd_lba", 64'(bus.sd_lba), 64'd0);
    void'(sb.pop_front());
    bus.cl_rd = '0; bus.sd_ack = '0; bus.sd_buff_wr = 1'b0;
    tick();
    reset = 1'b0;
    // Slots 0 and 2 compete; a cleared pointer must favour slot 0.
    run_txn('{4'b0101, 4'b0000, 32'h0000_0A00, 8'h0A, 0, 1'b0, 1, 2, 1'b0});
    run_txn('{4'b0100, 4'b0000, 32'h0000_0A02, 8'h0B, 2, 1'b0, 1, 2, 1'b0});

`ifdef SD_ARB_TIMEOUT_EN
    // No ack from hps_io: watchdog must abort with coincident err/done pulses.
    v = '{4'b0001, 4'b0000, 32'h0000_0777, 8'h77, 0, 1'b0, 0, 0, 1'b0};
    drive_req(v);
    wait_issue(lat);
    check("to_issue", 64'(bus.sd_rd), 64'h1);
    hi = 0;
    while (hi < 300) begin
      tick();
      hi++;
      if (bus.sd_rd == 4'b0) break;
    end
    check("to_window", 64'(hi >= 95 && hi <= 105), 64'd1);
    check("to_cl_done", 64'(bus.cl_done), 64'h1);
    check("to_cl_err", 64'(bus.cl_err), 64'h1);
    hi = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if ((bus.sd_rd | bus.cl_done | bus.cl_err) != 4'b0) hi++;
    end
    check("to_wait_rel", 64'(hi), 64'd0);
    void'(sb.pop_front());
    bus.cl_rd = '0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
